// File: rtl/axi_arb_rr.sv
// -----------------------------------------------------------------------------
// axi_arb_rr
//   N-master grant arbiter for the AXI interconnect. One master owns the bus at
//   a time. It keeps the grant until it strobes endtrans, or until the optional
//   hold timeout force-releases it. Simultaneous requesters are resolved
//   round-robin (RR_MODE=1) or by lowest index (RR_MODE=0). Every release is
//   followed by one IDLE cycle, so the owner never changes from one cycle to
//   the next.
//
// Parameters
//   NUM_MASTERS  number of requesters, 2..16
//   RR_MODE      1 = round-robin, 0 = fixed priority (lowest index wins)
//   MAX_HOLD     maximum grant length in cycles, 0 = no timeout, 0..65535
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   req          per-master request level
//   endtrans     per-master end-of-transaction strobe (owner bit only)
//   grant        registered one-hot grant, zero when there is no owner
//   grant_valid  high while a grant is held
//   grant_id     binary index of the owner, 0 when there is no owner
//   timeout      one-cycle pulse on a forced release
//
// States
//   S_IDLE  | no owner; picks a winner from req
//   S_GRANT | grant held until owner endtrans or hold timeout
// -----------------------------------------------------------------------------
module axi_arb_rr #(
  parameter  int NUM_MASTERS = 4,
  parameter  int RR_MODE     = 1,
  parameter  int MAX_HOLD    = 0,
  localparam int IDW         = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] endtrans,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   grant_valid,
  output logic [IDW-1:0]         grant_id,
  output logic                   timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam bit          HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [15:0] HOLD_LAST = HOLD_EN ? 16'(MAX_HOLD - 1) : 16'd0;
  localparam logic [15:0] HOLD_SAT  = 16'hFFFF;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic                   r_valid;
  logic [IDW-1:0]         r_grant_id;
  logic                   r_timeout;
  logic [15:0]            r_hold;
  logic [IDW-1:0]         r_last;

  logic                   w_found;
  logic [IDW-1:0]         w_win_id;
  logic [IDW-1:0]         w_idx;
  logic [NUM_MASTERS-1:0] w_win_onehot;
  logic                   w_owner_end;
  logic                   w_hold_expired;

  // Scan order starts just after the last owner in round-robin mode, so the
  // most recent owner is checked last. Fixed priority always starts at 0.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (RR_MODE != 0) begin
        w_idx = IDW'((int'(r_last) + 1 + i) % NUM_MASTERS);
      end else begin
        w_idx = IDW'(i);
      end
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_win_id = w_idx;
      end
    end
  end

  assign w_win_onehot   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win_id;
  assign w_owner_end    = endtrans[r_grant_id];
  assign w_hold_expired = HOLD_EN && (r_hold == HOLD_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_grant_id <= '0;
      r_timeout  <= 1'b0;
      r_hold     <= 16'd0;
      r_last     <= IDW'(NUM_MASTERS - 1);
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_GRANT;
            r_grant    <= w_win_onehot;
            r_valid    <= 1'b1;
            r_grant_id <= w_win_id;
            r_hold     <= 16'd0;
          end
        end
        S_GRANT: begin
          if (r_hold != HOLD_SAT) begin
            r_hold <= r_hold + 16'd1;
          end
          // Owner endtrans takes precedence over an expiring hold counter,
          // so a timeout pulse only appears on a genuinely stuck owner.
          if (w_owner_end || w_hold_expired) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_valid    <= 1'b0;
            r_grant_id <= '0;
            r_last     <= r_grant_id;
            r_timeout  <= !w_owner_end;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_id    = r_grant_id;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_axi_arb_rr.sv
// -----------------------------------------------------------------------------
// tb_axi_arb_rr
//   Bench for axi_arb_rr with three instances sharing clock, reset and inputs:
//   round-robin without timeout, fixed priority, and round-robin with
//   MAX_HOLD=5. Each scenario resets the design, then drives one step per
//   cycle, queues the output expected after the next edge, and compares it
//   against the instance under test.
// -----------------------------------------------------------------------------
module tb_axi_arb_rr;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] endtrans = 4'b0;

  logic [3:0] rr_grant, fp_grant, to_grant;
  logic [1:0] rr_id, fp_id, to_id;
  logic       rr_valid, fp_valid, to_valid;
  logic       rr_tmo, fp_tmo, to_tmo;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t q_exp[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  axi_arb_rr #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rstn(rstn), .req(req), .endtrans(endtrans),
    .grant(rr_grant), .grant_valid(rr_valid), .grant_id(rr_id), .timeout(rr_tmo)
  );

  axi_arb_rr #(.NUM_MASTERS(4), .RR_MODE(0), .MAX_HOLD(0)) u_fp (
    .clk(clk), .rstn(rstn), .req(req), .endtrans(endtrans),
    .grant(fp_grant), .grant_valid(fp_valid), .grant_id(fp_id), .timeout(fp_tmo)
  );

  axi_arb_rr #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(5)) u_to (
    .clk(clk), .rstn(rstn), .req(req), .endtrans(endtrans),
    .grant(to_grant), .grant_valid(to_valid), .grant_id(to_id), .timeout(to_tmo)
  );

  function automatic exp_t mk(input bit on, input int owner, input bit tmo);
    exp_t e;
    e.grant = on ? 4'(1 << owner) : 4'b0;
    e.id    = on ? 2'(owner) : 2'b0;
    e.valid = on;
    e.tmo   = tmo;
    return e;
  endfunction

  task automatic do_reset();
    rstn     = 1'b0;
    req      = 4'b0;
    endtrans = 4'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rstn     = 1'b0;
    req      = 4'b1111;
    endtrans = 4'b0;
    repeat (3) q_exp.push_back(mk(1'b0, 0, 1'b0));
    repeat (2) @(negedge clk);
    e = q_exp.pop_front(); checks += 4;
    if (rr_grant !== e.grant) begin errors++; $display("FAIL reset_rr grant=%b want %b", rr_grant, e.grant); end
    if (rr_id    !== e.id)    begin errors++; $display("FAIL reset_rr id=%0d want %0d", rr_id, e.id); end
    if (rr_valid !== e.valid) begin errors++; $display("FAIL reset_rr valid=%b want %b", rr_valid, e.valid); end
    if (rr_tmo   !== e.tmo)   begin errors++; $display("FAIL reset_rr timeout=%b want %b", rr_tmo, e.tmo); end
    e = q_exp.pop_front(); checks += 4;
    if (fp_grant !== e.grant) begin errors++; $display("FAIL reset_fp grant=%b want %b", fp_grant, e.grant); end
    if (fp_id    !== e.id)    begin errors++; $display("FAIL reset_fp id=%0d want %0d", fp_id, e.id); end
    if (fp_valid !== e.valid) begin errors++; $display("FAIL reset_fp valid=%b want %b", fp_valid, e.valid); end
    if (fp_tmo   !== e.tmo)   begin errors++; $display("FAIL reset_fp timeout=%b want %b", fp_tmo, e.tmo); end
    e = q_exp.pop_front(); checks += 4;
    if (to_grant !== e.grant) begin errors++; $display("FAIL reset_to grant=%b want %b", to_grant, e.grant); end
    if (to_id    !== e.id)    begin errors++; $display("FAIL reset_to id=%0d want %0d", to_id, e.id); end
    if (to_valid !== e.valid) begin errors++; $display("FAIL reset_to valid=%b want %b", to_valid, e.valid); end
    if (to_tmo   !== e.tmo)   begin errors++; $display("FAIL reset_to timeout=%b want %b", to_tmo, e.tmo); end
    req = 4'b0;
  endtask

  // req=0100 then an endtrans[2] pulse.
  task automatic test_single();
    exp_t e;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      req      = (s == 0) ? 4'b0100 : 4'b0000;
      endtrans = (s == 1) ? 4'b0100 : 4'b0000;
      q_exp.push_back(mk(s == 0, 2, 1'b0));
      @(negedge clk);
      e = q_exp.pop_front(); checks += 4;
      if (rr_grant !== e.grant) begin errors++; $display("FAIL single s%0d grant=%b want %b", s, rr_grant, e.grant); end
      if (rr_id    !== e.id)    begin errors++; $display("FAIL single s%0d id=%0d want %0d", s, rr_id, e.id); end
      if (rr_valid !== e.valid) begin errors++; $display("FAIL single s%0d valid=%b want %b", s, rr_valid, e.valid); end
      if (rr_tmo   !== e.tmo)   begin errors++; $display("FAIL single s%0d timeout=%b want %b", s, rr_tmo, e.tmo); end
    end
    endtrans = 4'b0;
  endtask

  // All four request continuously; each owner ends in its third grant cycle.
  // Expected: owners 0,1,2,3,0, three grant cycles each, one idle between.
  task automatic test_round_robin();
    exp_t e;
    do_reset();
    for (int s = 0; s < 17; s++) begin
      req      = 4'b1111;
      endtrans = (s % 4 == 3) ? 4'(1 << ((s / 4) % 4)) : 4'b0000;
      q_exp.push_back(mk(s % 4 != 3, (s / 4) % 4, 1'b0));
      @(negedge clk);
      e = q_exp.pop_front(); checks += 4;
      if (rr_grant !== e.grant) begin errors++; $display("FAIL rr_order s%0d grant=%b want %b", s, rr_grant, e.grant); end
      if (rr_id    !== e.id)    begin errors++; $display("FAIL rr_order s%0d id=%0d want %0d", s, rr_id, e.id); end
      if (rr_valid !== e.valid) begin errors++; $display("FAIL rr_order s%0d valid=%b want %b", s, rr_valid, e.valid); end
      if (rr_tmo   !== e.tmo)   begin errors++; $display("FAIL rr_order s%0d timeout=%b want %b", s, rr_tmo, e.tmo); end
    end
    req      = 4'b0;
    endtrans = 4'b0;
  endtask

  // req=1010 held, each owner ends in its second cycle: master 1 every time.
  task automatic test_fixed_priority();
    exp_t e;
    do_reset();
    for (int s = 0; s < 9; s++) begin
      req      = 4'b1010;
      endtrans = (s % 3 == 2) ? 4'b0010 : 4'b0000;
      q_exp.push_back(mk(s % 3 != 2, 1, 1'b0));
      @(negedge clk);
      e = q_exp.pop_front(); checks += 4;
      if (fp_grant !== e.grant) begin errors++; $display("FAIL fixed_prio s%0d grant=%b want %b", s, fp_grant, e.grant); end
      if (fp_id    !== e.id)    begin errors++; $display("FAIL fixed_prio s%0d id=%0d want %0d", s, fp_id, e.id); end
      if (fp_valid !== e.valid) begin errors++; $display("FAIL fixed_prio s%0d valid=%b want %b", s, fp_valid, e.valid); end
      if (fp_tmo   !== e.tmo)   begin errors++; $display("FAIL fixed_prio s%0d timeout=%b want %b", s, fp_tmo, e.tmo); end
    end
    req      = 4'b0;
    endtrans = 4'b0;
  endtask

  // MAX_HOLD=5. First grant: no endtrans, 5 grant cycles then a timeout
  // pulse. Second grant: endtrans in the 5th cycle, release with no pulse.
  task automatic test_timeout();
    exp_t e;
    do_reset();
    for (int s = 0; s < 14; s++) begin
      req      = (s == 0 || s == 7) ? 4'b0001 : 4'b0000;
      endtrans = (s == 12) ? 4'b0001 : 4'b0000;
      q_exp.push_back(mk((s <= 4) || (s >= 7 && s <= 11), 0, s == 5));
      @(negedge clk);
      e = q_exp.pop_front(); checks += 4;
      if (to_grant !== e.grant) begin errors++; $display("FAIL timeout s%0d grant=%b want %b", s, to_grant, e.grant); end
      if (to_id    !== e.id)    begin errors++; $display("FAIL timeout s%0d id=%0d want %0d", s, to_id, e.id); end
      if (to_valid !== e.valid) begin errors++; $display("FAIL timeout s%0d valid=%b want %b", s, to_valid, e.valid); end
      if (to_tmo   !== e.tmo)   begin errors++; $display("FAIL timeout s%0d timeout=%b want %b", s, to_tmo, e.tmo); end
    end
    endtrans = 4'b0;
  endtask

  // Master 0 owns; non-owner endtrans and requests, and the dropped req[0],
  // must not disturb it. After release, master 1 is next in rotation.
  task automatic test_ignored_events();
    exp_t e;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      req      = (s == 0) ? 4'b0001 : 4'b0110;
      endtrans = (s == 1 || s == 2) ? 4'b0110 : ((s == 3) ? 4'b0001 : 4'b0000);
      q_exp.push_back(mk(s <= 2 || s == 4, (s == 4) ? 1 : 0, 1'b0));
      @(negedge clk);
      e = q_exp.pop_front(); checks += 4;
      if (rr_grant !== e.grant) begin errors++; $display("FAIL ignored s%0d grant=%b want %b", s, rr_grant, e.grant); end
      if (rr_id    !== e.id)    begin errors++; $display("FAIL ignored s%0d id=%0d want %0d", s, rr_id, e.id); end
      if (rr_valid !== e.valid) begin errors++; $display("FAIL ignored s%0d valid=%b want %b", s, rr_valid, e.valid); end
      if (rr_tmo   !== e.tmo)   begin errors++; $display("FAIL ignored s%0d timeout=%b want %b", s, rr_tmo, e.tmo); end
    end
    req      = 4'b0;
    endtrans = 4'b0;
  endtask

  // Move the pointer to 1, grant master 2, then reset asynchronously between
  // edges. Outputs must clear at once and req=1111 must go to master 0.
  task automatic test_reset_mid_grant();
    exp_t e;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      req      = (s == 0) ? 4'b0010 : ((s == 1) ? 4'b0000 : 4'b0100);
      endtrans = (s == 1) ? 4'b0010 : 4'b0000;
      q_exp.push_back(mk(s != 1, (s == 0) ? 1 : 2, 1'b0));
      @(negedge clk);
      e = q_exp.pop_front(); checks += 4;
      if (rr_grant !== e.grant) begin errors++; $display("FAIL midrst_pre s%0d grant=%b want %b", s, rr_grant, e.grant); end
      if (rr_id    !== e.id)    begin errors++; $display("FAIL midrst_pre s%0d id=%0d want %0d", s, rr_id, e.id); end
      if (rr_valid !== e.valid) begin errors++; $display("FAIL midrst_pre s%0d valid=%b want %b", s, rr_valid, e.valid); end
      if (rr_tmo   !== e.tmo)   begin errors++; $display("FAIL midrst_pre s%0d timeout=%b want %b", s, rr_tmo, e.tmo); end
    end
    q_exp.push_back(mk(1'b0, 0, 1'b0));
    #2 rstn = 1'b0;
    #1;
    e = q_exp.pop_front(); checks += 4;
    if (rr_grant !== e.grant) begin errors++; $display("FAIL midrst_async grant=%b want %b", rr_grant, e.grant); end
    if (rr_id    !== e.id)    begin errors++; $display("FAIL midrst_async id=%0d want %0d", rr_id, e.id); end
    if (rr_valid !== e.valid) begin errors++; $display("FAIL midrst_async valid=%b want %b", rr_valid, e.valid); end
    if (rr_tmo   !== e.tmo)   begin errors++; $display("FAIL midrst_async timeout=%b want %b", rr_tmo, e.tmo); end
    @(negedge clk);
    rstn = 1'b1;
    req  = 4'b1111;
    q_exp.push_back(mk(1'b1, 0, 1'b0));
    @(negedge clk);
    e = q_exp.pop_front(); checks += 4;
    if (rr_grant !== e.grant) begin errors++; $display("FAIL midrst_next grant=%b want %b", rr_grant, e.grant); end
    if (rr_id    !== e.id)    begin errors++; $display("FAIL midrst_next id=%0d want %0d", rr_id, e.id); end
    if (rr_valid !== e.valid) begin errors++; $display("FAIL midrst_next valid=%b want %b", rr_valid, e.valid); end
    if (rr_tmo   !== e.tmo)   begin errors++; $display("FAIL midrst_next timeout=%b want %b", rr_tmo, e.tmo); end
    req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_ignored_events();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
